// File: rtl/clock_period_meter_pkg.sv
// Shared types and helpers for the clock period meter.
package clock_period_meter_pkg;

    localparam int unsigned DefaultCntWidth = 16;

    typedef enum logic [1:0] {
        StWaitLow = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2,
        StStall   = 2'd3
    } state_e;

    // Lower lock bound, clamped at zero when the tolerance exceeds the expected period.
    function automatic int unsigned lock_lo(input int unsigned exp_period,
                                            input int unsigned tolerance);
        return (exp_period > tolerance) ? exp_period - tolerance : 0;
    endfunction

    function automatic int unsigned lock_hi(input int unsigned exp_period,
                                            input int unsigned tolerance);
        return exp_period + tolerance;
    endfunction

endpackage

// File: rtl/clock_period_meter_if.sv
// Measurement result bundle produced by the clock period meter.
interface clock_period_meter_if #(
    parameter int unsigned CntWidth = 16
);
    logic [CntWidth-1:0] period;
    logic [CntWidth-1:0] high_time;
    logic                period_valid;
    logic                stalled;
    logic                locked;

    modport master (
        output period, high_time, period_valid, stalled, locked
    );

    modport slave (
        input period, high_time, period_valid, stalled, locked
    );
endinterface

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Multi-flop synchronizer with rise/fall pulse generation on the synchronized level.
module clock_period_meter_sync_edge_detect #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SyncStages-1:0] sync_q;
    logic                  edge_q;

    // Shift the asynchronous input through the synchronizer and keep one delayed copy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], async_i};
            edge_q <= sync_q[SyncStages-1];
        end
    end

    assign level_o = sync_q[SyncStages-1];
    assign rise_o  = sync_q[SyncStages-1] & ~edge_q;
    assign fall_o  = ~sync_q[SyncStages-1] & edge_q;
endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock, flags stalls and tracks lock.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int unsigned CntWidth      = DefaultCntWidth,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned TimeoutCycles = 65535,
    parameter int unsigned ExpPeriod     = 5002,
    parameter int unsigned Tolerance     = 8,
    parameter int unsigned LockCount     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clk_meas_i,
    clock_period_meter_if.master        meas_if
);
    localparam int unsigned StreakW = $clog2(LockCount + 1);
    localparam int unsigned FillW   = $clog2(SyncStages + 1);

    localparam logic [CntWidth:0]   LockLo    = (CntWidth+1)'(lock_lo(ExpPeriod, Tolerance));
    localparam logic [CntWidth:0]   LockHi    = (CntWidth+1)'(lock_hi(ExpPeriod, Tolerance));
    localparam logic [CntWidth-1:0] TimeoutM1 = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntMax    = '1;
    localparam logic [StreakW-1:0]  LockMax   = StreakW'(LockCount);
    localparam logic [FillW-1:0]    FillDone  = FillW'(SyncStages);

    logic level, rise, fall;

    clock_period_meter_sync_edge_detect #(
        .SyncStages (SyncStages)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (clk_meas_i),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, pend_q, pend_d;
    logic [CntWidth-1:0] period_q, period_d, high_q, high_d;
    logic                fall_seen_q, fall_seen_d;
    logic                valid_q, valid_d, stalled_q, stalled_d, locked_q, locked_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [CntWidth-1:0] meas_period;
    logic                in_range;

    assign meas_period = cnt_q + 1'b1;
    assign in_range    = ({1'b0, meas_period} >= LockLo) && ({1'b0, meas_period} <= LockHi);

    // Next-state logic for counters, FSM, capture registers and lock tracker.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        fall_seen_d = fall_seen_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        stalled_d   = stalled_q;
        locked_d    = locked_q;
        streak_d    = streak_q;
        fill_d      = (fill_q == FillDone) ? fill_q : fill_q + 1'b1;

        // Counters saturate so an idle input outside MEASURE never wraps them.
        cnt_d  = rise ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1);
        hcnt_d = rise ? '0 : ((fall_seen_q || hcnt_q == CntMax) ? hcnt_q : hcnt_q + 1'b1);
        if (rise) begin
            fall_seen_d = 1'b0;
        end

        unique case (state_q)
            StWaitLow: begin
                // Only trust the level once the synchronizer holds real samples.
                if (fill_q == FillDone && !level) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (rise) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (fall) begin
                    pend_d      = hcnt_q + 1'b1;
                    fall_seen_d = 1'b1;
                end
                if (rise) begin
                    period_d = meas_period;
                    high_d   = fall_seen_q ? pend_q : meas_period;
                    valid_d  = 1'b1;
                    if (in_range) begin
                        streak_d = (streak_q == LockMax) ? streak_q : streak_q + 1'b1;
                        locked_d = (streak_d == LockMax);
                    end else begin
                        streak_d = '0;
                        locked_d = 1'b0;
                    end
                end else if (cnt_q == TimeoutM1) begin
                    state_d   = StStall;
                    stalled_d = 1'b1;
                    locked_d  = 1'b0;
                    streak_d  = '0;
                end
            end
            StStall: begin
                if (rise) begin
                    stalled_d = 1'b0;
                    state_d   = StMeasure;
                end
            end
            default: state_d = StWaitLow;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StWaitLow;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            pend_q      <= '0;
            fall_seen_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
            locked_q    <= 1'b0;
            streak_q    <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            pend_q      <= pend_d;
            fall_seen_q <= fall_seen_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            stalled_q   <= stalled_d;
            locked_q    <= locked_d;
            streak_q    <= streak_d;
            fill_q      <= fill_d;
        end
    end

    assign meas_if.period       = period_q;
    assign meas_if.high_time    = high_q;
    assign meas_if.period_valid = valid_q;
    assign meas_if.stalled      = stalled_q;
    assign meas_if.locked       = locked_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter using scaled-down timing parameters.
module tb_clock_period_meter;
    localparam int unsigned Cw      = 16;
    localparam int unsigned Timeout = 300;
    localparam int unsigned ExpP    = 100;
    localparam int unsigned Tol     = 3;
    localparam int unsigned LockN   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_meas = 1'b0;
    int   cyc = 0;

    clock_period_meter_if #(.CntWidth(Cw)) meas_if ();

    clock_period_meter #(
        .CntWidth      (Cw),
        .SyncStages    (2),
        .TimeoutCycles (Timeout),
        .ExpPeriod     (ExpP),
        .Tolerance     (Tol),
        .LockCount     (LockN)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clk_meas_i (clk_meas),
        .meas_if    (meas_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned high;
        int unsigned low;
        int unsigned exp_period;
        int unsigned exp_high;
        bit          exp_locked;
    } vec_t;

    typedef struct {
        int unsigned period;
        int unsigned high;
        bit          locked;
    } rep_t;

    rep_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_valid_cyc = 0;

    // Reference model state: a period closes on each driven rise.
    bit          armed = 1'b0;
    int unsigned prev_h = 0, prev_l = 0;
    bit          pend_use_tbl = 1'b0;
    vec_t        pend_tbl;
    int unsigned streak = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, want, cyc);
        end
    endtask

    task automatic close_period();
        int unsigned p;
        rep_t r;
        if (armed) begin
            p = prev_h + prev_l;
            if (p > Timeout) begin
                streak = 0;
            end else begin
                if (p >= ExpP - Tol && p <= ExpP + Tol) streak = (streak < LockN) ? streak + 1 : LockN;
                else streak = 0;
                if (pend_use_tbl) begin
                    r.period = pend_tbl.exp_period;
                    r.high   = pend_tbl.exp_high;
                    r.locked = pend_tbl.exp_locked;
                end else begin
                    r.period = p;
                    r.high   = prev_h;
                    r.locked = (streak == LockN);
                end
                exp_q.push_back(r);
            end
        end
    endtask

    // Called at a negedge; drives one full high/low period starting with a rise.
    task automatic send_period(input int unsigned h, input int unsigned l,
                               input bit use_tbl, input vec_t rec);
        close_period();
        armed        = 1'b1;
        prev_h       = h;
        prev_l       = l;
        pend_use_tbl = use_tbl;
        pend_tbl     = rec;
        clk_meas = 1'b1;
        repeat (h) @(negedge clk);
        clk_meas = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, int'(meas_if.period), 0);
        check({tag, "_high"}, int'(meas_if.high_time), 0);
        check({tag, "_valid"}, int'(meas_if.period_valid), 0);
        check({tag, "_stalled"}, int'(meas_if.stalled), 0);
        check({tag, "_locked"}, int'(meas_if.locked), 0);
    endtask

    // Every PERIOD_VALID pulse must match the next expected report.
    always @(negedge clk) begin
        if (!rst && meas_if.period_valid) begin
            last_valid_cyc <= cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", int'(meas_if.period), -1);
            end else begin
                rep_t e;
                e = exp_q.pop_front();
                check("period", int'(meas_if.period), int'(e.period));
                check("high_time", int'(meas_if.high_time), int'(e.high));
                check("locked", int'(meas_if.locked), int'(e.locked));
            end
        end
    end

    vec_t tbl[18];
    vec_t none;

    initial begin
        int waited;
        int unsigned p, h;
        none = '{0, 0, 0, 0, 1'b0};
        tbl[0]  = '{50, 50, 100, 50, 1'b0};
        tbl[1]  = '{50, 50, 100, 50, 1'b0};
        tbl[2]  = '{25, 75, 100, 25, 1'b0};
        tbl[3]  = '{60, 43, 103, 60, 1'b1};
        tbl[4]  = '{50, 47, 97, 50, 1'b1};
        tbl[5]  = '{50, 54, 104, 50, 1'b0};
        tbl[6]  = '{50, 50, 100, 50, 1'b0};
        tbl[7]  = '{30, 66, 96, 30, 1'b0};
        tbl[8]  = '{50, 50, 100, 50, 1'b0};
        tbl[9]  = '{50, 50, 100, 50, 1'b0};
        tbl[10] = '{50, 50, 100, 50, 1'b0};
        tbl[11] = '{50, 50, 100, 50, 1'b1};
        tbl[12] = '{1, 99, 100, 1, 1'b1};
        tbl[13] = '{150, 150, 300, 150, 1'b0};
        tbl[14] = '{50, 50, 100, 50, 1'b0};
        tbl[15] = '{50, 50, 100, 50, 1'b0};
        tbl[16] = '{50, 50, 100, 50, 1'b0};
        tbl[17] = '{50, 50, 100, 50, 1'b1};

        // Input held high through reset: no false rise may be measured.
        clk_meas = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (37) @(negedge clk);
        clk_meas = 1'b0;
        repeat (40) @(negedge clk);

        // Table-driven periods: tolerance edges, short high, period equal to timeout.
        for (int i = 0; i < 18; i++) begin
            send_period(tbl[i].high, tbl[i].low, 1'b1, tbl[i]);
        end

        // Stall: line stays low after a locked report.
        send_period(50, 50, 1'b0, none);
        waited = 0;
        while (cyc < last_valid_cyc + int'(Timeout) - 1) begin
            @(negedge clk);
            waited++;
        end
        check("stall_not_yet", int'(meas_if.stalled), 0);
        @(negedge clk);
        waited++;
        check("stall_set", int'(meas_if.stalled), 1);
        check("stall_locked", int'(meas_if.locked), 0);
        prev_l = prev_l + waited;
        send_period(50, 50, 1'b0, none);
        check("stall_cleared", int'(meas_if.stalled), 0);
        check("stall_unlocked", int'(meas_if.locked), 0);

        // Randomized periods against the reference model.
        for (int i = 0; i < 16; i++) begin
            p = ($urandom_range(0, 1) == 1) ? $urandom_range(ExpP - 5, ExpP + 5)
                                             : $urandom_range(20, 200);
            h = $urandom_range(1, p - 1);
            send_period(h, p - h, 1'b0, none);
        end

        // Lock up, then reset for one cycle in the middle of a high phase.
        for (int i = 0; i < 5; i++) send_period(50, 50, 1'b0, none);
        close_period();
        armed = 1'b0;
        clk_meas = 1'b1;
        repeat (20) @(negedge clk);
        check("pre_reset_locked", int'(meas_if.locked), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");
        streak = 0;
        repeat (29) @(negedge clk);
        clk_meas = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 3; i++) send_period(50, 50, 1'b0, none);
        repeat (20) @(negedge clk);
        check("reports_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
